ysyx_25020047_lsu: RTL
======================

YSYX_25020047_LSU -- requirements
Module: ysyx_25020047_lsu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum WAIT cycles before a bus error is forced.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  core load/store request.
REQ-005 req_ready  output  1  LSU can accept a request.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte address (EXU result).
REQ-008 req_wdata  input  32  store data (rs2).
REQ-009 req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-010 req_unsigned  input  1  zero-extend load (lbu/lhu).
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  output  1  misaligned, illegal size, bus error or timeout; valid with resp_valid.
REQ-014 busy  output  1  high in any state except IDLE; core stall.
REQ-015 mem_req_valid / mem_req_ready  output / input  1 / 1  bus request handshake.
REQ-016 mem_req_we  output  1  bus write enable.
REQ-017 mem_req_addr  output  32  word-aligned address: {req_addr[31:2], 2'b00}.
REQ-018 mem_req_wdata  output  32  lane-replicated store data.
REQ-019 mem_req_wstrb  output  4  byte-lane strobes; 0 on reads.
REQ-020 mem_resp_valid / mem_resp_ready  input / output  1 / 1  bus response handshake.
REQ-021 mem_resp_rdata  input  32  raw word read from memory.
REQ-022 mem_resp_err  input  1  bus error flag.

Function
REQ-023 FSM states SHALL be IDLE, REQ, WAIT, RESP; req_ready = (state == IDLE).
REQ-024 IDLE with req_valid SHALL latch write, addr, wdata, size and unsigned; go to REQ, or to RESP with err = 1 if misaligned (half: addr[0] = 1; word: addr[1:0] != 0) or size == 3, with no bus traffic.
REQ-025 REQ SHALL hold mem_req_valid = 1 with a stable payload until mem_req_ready, then go to WAIT; no combinational path from mem_req_ready to the payload.
REQ-026 wstrb SHALL be: byte 4'b0001 << addr[1:0]; half 4'b0011 << {addr[1], 1'b0}; word 4'b1111.
REQ-027 wdata SHALL be: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-028 WAIT SHALL drive mem_resp_ready = 1; on mem_resp_valid, register the lane-extracted data (rdata >> 8*addr[1:0], trimmed to size, sign- or zero-extended) and mem_resp_err, then go to RESP.
REQ-029 WAIT SHALL count cycles; on reaching TIMEOUT_CYCLES without mem_resp_valid it SHALL go to RESP with err = 1 and rdata = 0; the counter clears on entry to WAIT.
REQ-030 RESP SHALL assert resp_valid for exactly one cycle, then return to IDLE; the request is not re-accepted in the same cycle.
REQ-031 Latency with zero-wait memory (ready and resp_valid high immediately) SHALL be 3 cycles from the accepting edge to resp_valid high; the misaligned error path SHALL take 1 cycle.
REQ-032 mem_resp_valid outside WAIT SHALL be ignored.
REQ-033 On a store, resp_rdata SHALL be 0 and resp_err = mem_resp_err.

Reset
REQ-034 rst_n low SHALL force IDLE immediately, independent of clk, and clear all outputs to 0 (req_ready = 1 after release) and the timeout counter; an in-flight transaction is dropped with no resp_valid.
REQ-035 Reset deassertion SHALL be synchronised by the integrator; the LSU requires no extra cycles after release.

Structure
REQ-036 Shared package ysyx_25020047_pkg SHALL hold the state encodings, SIZE_B/SIZE_H/SIZE_W/SIZE_X constants and the default TIMEOUT_CYCLES.
REQ-037 Lane alignment (wstrb, wdata replication, load extract/extend) SHALL be one combinational sub-module, ysyx_25020047_lsu_align, shared by the store and load paths.

Verification
REQ-038 lw addr 0x80000004, mem returns 0xDEADBEEF with zero wait -> mem_req_addr 0x80000004, wstrb 0, resp_rdata 0xDEADBEEF, resp_valid 3 cycles after accept.
REQ-039 lb addr 0x80000003 with 0x80FF1234 -> 0xFFFFFF80; lbu at the same address -> 0x00000080; lh addr 0x80000002 -> 0xFFFF80FF.
REQ-040 sb addr 0x80000001 with wdata 0x000000AB -> wstrb 4'b0010, mem_req_wdata 0xABABABAB, mem_req_we 1; sh addr 0x80000002 -> wstrb 4'b1100.
REQ-041 lw addr 0x80000002 -> no mem_req_valid, resp_valid with resp_err 1 one cycle after accept; size 3 -> same.
REQ-042 mem_req_ready held low 5 cycles, then mem_resp_valid never asserted -> payload stable throughout REQ; resp_err 1 after TIMEOUT_CYCLES in WAIT.
REQ-043 rst_n pulled low during WAIT -> busy 0 and req_ready 1 immediately; no resp_valid; a new lw after release completes normally.

Source files
------------

// File: rtl/ysyx_25020047_pkg.sv
// ysyx_25020047_pkg: shared LSU state encodings, access sizes and defaults
package ysyx_25020047_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_X = 2'd3;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    // Requests that can never reach the bus: illegal size or a misaligned half/word
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        return size == SIZE_X || (size == SIZE_H && a[0]) || (size == SIZE_W && a != 2'b00);
    endfunction

endpackage

// File: rtl/ysyx_25020047_lsu_align.sv
// ysyx_25020047_lsu_align: byte-lane strobes, store replication and load extract/extend
module ysyx_25020047_lsu_align
    import ysyx_25020047_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        zext,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] sh;

    assign sh = rdata >> {addr, 3'b000};

    assign wstrb = size == SIZE_B ? 4'b0001 << addr
                 : size == SIZE_H ? 4'b0011 << {addr[1], 1'b0}
                 : 4'b1111;

    assign wdata_rep = size == SIZE_B ? {4{wdata[7:0]}}
                     : size == SIZE_H ? {2{wdata[15:0]}}
                     : wdata;

    assign rdata_ext = size == SIZE_B ? {{24{sh[7] & ~zext}}, sh[7:0]}
                     : size == SIZE_H ? {{16{sh[15] & ~zext}}, sh[15:0]}
                     : sh;

endmodule

// File: rtl/ysyx_25020047_lsu.sv
// ysyx_25020047_lsu: load/store unit bridging core requests to a valid/ready memory bus
module ysyx_25020047_lsu
    import ysyx_25020047_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wstrb,
    input  logic        mem_resp_valid,
    output logic        mem_resp_ready,
    input  logic [31:0] mem_resp_rdata,
    input  logic        mem_resp_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e  state_q, state_d;
    logic        we_q, uns_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]  strb;
    logic [31:0] wrep, rext;
    logic        bad, timeout;

    ysyx_25020047_lsu_align u_align (
        .addr      (addr_q[1:0]),
        .size      (size_q),
        .zext      (uns_q),
        .wdata     (wdata_q),
        .rdata     (mem_resp_rdata),
        .wstrb     (strb),
        .wdata_rep (wrep),
        .rdata_ext (rext)
    );

    assign bad     = misaligned(req_size, req_addr[1:0]);
    assign timeout = cnt_q == CW'(TIMEOUT_CYCLES - 1);

    // Payload comes only from registers, so mem_req_ready never reaches it
    assign req_ready      = state_q == IDLE;
    assign busy           = state_q != IDLE;
    assign mem_req_valid  = state_q == REQ;
    assign mem_req_we     = we_q;
    assign mem_req_addr   = {addr_q[31:2], 2'b00};
    assign mem_req_wdata  = wrep;
    assign mem_req_wstrb  = we_q ? strb : 4'b0000;
    assign mem_resp_ready = state_q == WAIT;
    assign resp_valid     = state_q == RESP;
    assign resp_rdata     = resp_valid ? rdata_q : 32'h0;
    assign resp_err       = resp_valid & err_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = req_valid ? (bad ? RESP : REQ) : IDLE;
            REQ:     state_d = mem_req_ready ? WAIT : REQ;
            WAIT:    state_d = (mem_resp_valid || timeout) ? RESP : WAIT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                we_q    <= req_write;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= bad;
                rdata_q <= 32'h0;
            end
            if (state_q == REQ)
                cnt_q <= '0;
            if (state_q == WAIT) begin
                cnt_q <= cnt_q + CW'(1);
                if (mem_resp_valid) begin
                    rdata_q <= (we_q || mem_resp_err) ? 32'h0 : rext;
                    err_q   <= mem_resp_err;
                end else if (timeout) begin
                    rdata_q <= 32'h0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

endmodule
